// File: rtl/obstacle_scheduler.sv
// Obstacle slot scheduler: spawns, scrolls and retires NUM_SLOTS obstacles once per frame tick.
// Spawn spacing and obstacle type come from a 16-bit Galois LFSR; the scroll step ramps up over time.
module obstacle_scheduler #(
  parameter int unsigned NUM_SLOTS      = 3,
  parameter int unsigned SCREEN_W       = 640,
  parameter int unsigned DX_INIT        = 5,
  parameter int unsigned DX_MAX         = 12,
  parameter int unsigned SPEEDUP_FRAMES = 600,
  parameter int unsigned MIN_GAP        = 200,
  parameter logic [7:0]  GAP_MASK       = 8'hFF,
  parameter int unsigned TYPE_COUNT     = 6,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_tick,
  input  logic [1:0]             gameState,
  input  logic [12*NUM_SLOTS-1:0] obs_w,
  output logic [12*NUM_SLOTS-1:0] obs_x,
  output logic [NUM_SLOTS-1:0]    obs_active,
  output logic [4*NUM_SLOTS-1:0]  obs_sel,
  output logic [7:0]             cur_dx,
  output logic                   spawn_pulse
);

  typedef enum logic [1:0] {
    GS_READY    = 2'b00,
    GS_PLAYING  = 2'b01,
    GS_OVER     = 2'b10,
    GS_OVER_ALT = 2'b11
  } game_state_t;

  localparam logic [11:0] X_SPAWN  = 12'(SCREEN_W);
  localparam logic [7:0]  DX0      = 8'(DX_INIT);
  localparam logic [7:0]  DXM      = 8'(DX_MAX);
  localparam logic [15:0] SPD_LAST = 16'(SPEEDUP_FRAMES - 1);
  localparam logic [15:0] GAP_BASE = 16'(MIN_GAP);
  localparam logic [4:0]  TYPES    = 5'(TYPE_COUNT);

  logic [15:0] gap_cnt, next_gap, speed_cnt, lfsr;

  logic [12*NUM_SLOTS-1:0] x_d;
  logic [NUM_SLOTS-1:0]    act_d;
  logic [4*NUM_SLOTS-1:0]  sel_d;
  logic [7:0]              dx_d;
  logic [15:0]             gap_d, ngap_d, spd_d, lfsr_d;
  logic                    pulse_d;

  game_state_t gs;
  logic        spawn_ok, taken;
  logic [12:0] x13;
  logic [13:0] reach;
  logic [16:0] gap_sum;
  logic [4:0]  sel_wide;

  assign gs       = game_state_t'(gameState);
  assign spawn_ok = (gap_cnt >= next_gap);
  assign gap_sum  = {1'b0, gap_cnt} + {9'b0, cur_dx};
  assign sel_wide = {1'b0, lfsr[3:0]} % TYPES;

  always_comb begin
    x_d     = obs_x;
    act_d   = obs_active;
    sel_d   = obs_sel;
    dx_d    = cur_dx;
    gap_d   = gap_cnt;
    ngap_d  = next_gap;
    spd_d   = speed_cnt;
    lfsr_d  = lfsr;
    pulse_d = 1'b0;
    taken   = 1'b0;
    x13     = '0;
    reach   = '0;
    if (frame_tick) begin
      case (gs)
        GS_READY: begin
          x_d    = {NUM_SLOTS{X_SPAWN}};
          act_d  = '0;
          sel_d  = '0;
          dx_d   = DX0;
          gap_d  = '0;
          ngap_d = '0;
          spd_d  = '0;
        end
        GS_PLAYING: begin
          // Active slots scroll; the first slot that was already free before this frame takes a spawn.
          for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (obs_active[i]) begin
              x13   = {obs_x[12*i+11], obs_x[12*i +: 12]} - {5'b0, cur_dx};
              reach = {x13[12], x13} + {2'b00, obs_w[12*i +: 12]};
              x_d[12*i +: 12] = x13[11:0];
              if (reach[13] || reach == '0) act_d[i] = 1'b0;
            end else if (spawn_ok && !taken) begin
              taken            = 1'b1;
              x_d[12*i +: 12]  = X_SPAWN;
              act_d[i]         = 1'b1;
              sel_d[4*i +: 4]  = sel_wide[3:0];
            end
          end
          gap_d = gap_sum[16] ? '1 : gap_sum[15:0];
          if (taken) begin
            gap_d   = '0;
            ngap_d  = GAP_BASE + {8'h00, lfsr[7:0] & GAP_MASK};
            pulse_d = 1'b1;
          end
          if (speed_cnt == SPD_LAST) begin
            spd_d = '0;
            dx_d  = (cur_dx >= DXM) ? DXM : cur_dx + 8'd1;
          end else begin
            spd_d = speed_cnt + 16'd1;
          end
          lfsr_d = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      obs_x       <= {NUM_SLOTS{X_SPAWN}};
      obs_active  <= '0;
      obs_sel     <= '0;
      cur_dx      <= DX0;
      spawn_pulse <= 1'b0;
      gap_cnt     <= '0;
      next_gap    <= '0;
      speed_cnt   <= '0;
      lfsr        <= LFSR_SEED;
    end else begin
      obs_x       <= x_d;
      obs_active  <= act_d;
      obs_sel     <= sel_d;
      cur_dx      <= dx_d;
      spawn_pulse <= pulse_d;
      gap_cnt     <= gap_d;
      next_gap    <= ngap_d;
      speed_cnt   <= spd_d;
      lfsr        <= lfsr_d;
    end
  end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Bench for obstacle_scheduler: three parameterisations driven in lockstep against a
// per-instance behavioural model, with directed scenarios followed by random play.
module tb_obstacle_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic [1:0] game_state = 2'b01;
  int         wv[3][8];

  logic [35:0] w_a, w_c, a_x, c_x;
  logic [11:0] w_b, b_x, a_sel, c_sel;
  logic [2:0]  a_act, c_act;
  logic [0:0]  b_act;
  logic [3:0]  b_sel;
  logic [7:0]  a_dx, b_dx, c_dx;
  logic        a_p, b_p, c_p;

  assign w_a = {12'(wv[0][2]), 12'(wv[0][1]), 12'(wv[0][0])};
  assign w_b = 12'(wv[1][0]);
  assign w_c = {12'(wv[2][2]), 12'(wv[2][1]), 12'(wv[2][0])};

  obstacle_scheduler dut_a (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .gameState(game_state), .obs_w(w_a),
    .obs_x(a_x), .obs_active(a_act), .obs_sel(a_sel), .cur_dx(a_dx), .spawn_pulse(a_p));

  obstacle_scheduler #(.NUM_SLOTS(1), .MIN_GAP(10), .GAP_MASK(8'h00)) dut_b (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .gameState(game_state), .obs_w(w_b),
    .obs_x(b_x), .obs_active(b_act), .obs_sel(b_sel), .cur_dx(b_dx), .spawn_pulse(b_p));

  obstacle_scheduler #(.SPEEDUP_FRAMES(4), .DX_MAX(7)) dut_c (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .gameState(game_state), .obs_w(w_c),
    .obs_x(c_x), .obs_active(c_act), .obs_sel(c_sel), .cur_dx(c_dx), .spawn_pulse(c_p));

  int cn[3]     = '{3, 1, 3};
  int cdxmax[3] = '{12, 12, 7};
  int cspd[3]   = '{600, 600, 4};
  int cmgap[3]  = '{200, 10, 200};
  int cgmask[3] = '{255, 0, 255};

  // model state: x kept as its 12-bit pattern
  int mx[3][8];
  bit mact[3][8];
  int msel[3][8];
  int mdx[3], mgap[3], mngap[3], mspd[3], mlfsr[3];
  bit mp[3];

  int  checks = 0;
  int  errors = 0;
  bit  started = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_clear(input int d);
    for (int i = 0; i < 8; i++) begin
      mx[d][i] = 640; mact[d][i] = 1'b0; msel[d][i] = 0;
    end
    mdx[d] = 5; mgap[d] = 0; mngap[d] = 0; mspd[d] = 0;
  endtask

  task automatic m_step(input int d);
    int px[8];
    bit pact[8];
    int pdx, pgap, pngap, pspd, plfsr, fr, nx, sx;
    for (int i = 0; i < 8; i++) begin px[i] = mx[d][i]; pact[i] = mact[d][i]; end
    pdx = mdx[d]; pgap = mgap[d]; pngap = mngap[d]; pspd = mspd[d]; plfsr = mlfsr[d];
    mp[d] = 1'b0;
    if (rst) begin
      m_clear(d);
      mlfsr[d] = 'hACE1;
      return;
    end
    if (!frame_tick) return;
    if (game_state == 2'b00) begin
      m_clear(d);
      return;
    end
    if (game_state != 2'b01) return;
    fr = -1;
    for (int i = 0; i < cn[d]; i++) if (!pact[i] && fr < 0) fr = i;
    for (int i = 0; i < cn[d]; i++) begin
      if (pact[i]) begin
        sx = (px[i] >= 2048) ? px[i] - 4096 : px[i];
        nx = sx - pdx;
        mx[d][i] = nx & 'hFFF;
        if (nx + wv[d][i] <= 0) mact[d][i] = 1'b0;
      end
    end
    mgap[d] = (pgap + pdx > 65535) ? 65535 : pgap + pdx;
    if (pspd == cspd[d] - 1) begin
      mspd[d] = 0;
      mdx[d]  = (pdx + 1 > cdxmax[d]) ? cdxmax[d] : pdx + 1;
    end else begin
      mspd[d] = pspd + 1;
    end
    if (pgap >= pngap && fr >= 0) begin
      mx[d][fr]   = 640;
      mact[d][fr] = 1'b1;
      msel[d][fr] = (plfsr & 15) % 6;
      mngap[d]    = cmgap[d] + ((plfsr & 255) & cgmask[d]);
      mgap[d]     = 0;
      mp[d]       = 1'b1;
    end
    mlfsr[d] = (plfsr >> 1) ^ (((plfsr & 1) != 0) ? 'hB400 : 0);
  endtask

  always @(posedge clk) begin
    if (rst) started <= 1'b1;
    for (int d = 0; d < 3; d++) m_step(d);
  end

  task automatic cmp_dut(input int d, input logic [35:0] xv, input logic [7:0] av,
                         input logic [11:0] sv, input logic [7:0] dxv, input logic pv);
    for (int i = 0; i < cn[d]; i++) begin
      chk($sformatf("d%0d_x%0d", d, i), int'(xv[12*i +: 12]), mx[d][i]);
      chk($sformatf("d%0d_act%0d", d, i), int'(av[i]), int'(mact[d][i]));
      chk($sformatf("d%0d_sel%0d", d, i), int'(sv[4*i +: 4]), msel[d][i]);
    end
    chk($sformatf("d%0d_dx", d), int'(dxv), mdx[d]);
    chk($sformatf("d%0d_pulse", d), int'(pv), int'(mp[d]));
  endtask

  always @(negedge clk) begin
    if (started) begin
      cmp_dut(0, a_x, {5'b0, a_act}, a_sel, a_dx, a_p);
      cmp_dut(1, {24'b0, b_x}, {7'b0, b_act}, {8'b0, b_sel}, b_dx, b_p);
      cmp_dut(2, c_x, {5'b0, c_act}, c_sel, c_dx, c_p);
    end
  end

  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) for (int i = 0; i < 8; i++) wv[d][i] = 20;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_x0", int'(a_x[11:0]), 640);
    chk("rst_x2", int'(a_x[35:24]), 640);
    chk("rst_act", int'(a_act), 0);
    chk("rst_sel", int'(a_sel), 0);
    chk("rst_dx", int'(a_dx), 5);
    chk("rst_pulse", int'(a_p), 0);

    game_state = 2'b01;
    tick();
    chk("t1_act", int'(a_act), 1);
    chk("t1_x0", int'(a_x[11:0]), 640);
    chk("t1_sel0", int'(a_sel[3:0]), 1);
    chk("t1_pulse", int'(a_p), 1);
    chk("t1_model_ngap", mngap[0], 425);
    for (int t = 2; t <= 134; t++) begin
      tick();
      if (t == 2)   chk("t2_pulse", int'(a_p), 0);
      if (t == 4)   chk("c_dx_4", int'(c_dx), 6);
      if (t == 8)   chk("c_dx_8", int'(c_dx), 7);
      if (t == 11) begin
        chk("t11_x0", int'(a_x[11:0]), 590);
        chk("t11_act", int'(a_act), 1);
      end
      if (t == 40)  chk("c_dx_40", int'(c_dx), 7);
      if (t == 86)  chk("t86_act", int'(a_act), 1);
      if (t == 87) begin
        chk("t87_act", int'(a_act), 3);
        chk("t87_x1", int'(a_x[23:12]), 640);
        chk("t87_pulse", int'(a_p), 1);
      end
      if (t == 133) begin
        chk("b_retire_act", int'(b_act), 0);
        chk("b_retire_x", int'(b_x), 'hFEC);
        chk("b_retire_pulse", int'(b_p), 0);
      end
      if (t == 134) begin
        chk("b_respawn_act", int'(b_act), 1);
        chk("b_respawn_x", int'(b_x), 640);
        chk("b_respawn_pulse", int'(b_p), 1);
      end
    end

    game_state = 2'b10;
    repeat (50) tick();
    chk("frz_x1", int'(a_x[23:12]), 405);
    chk("frz_act1", int'(a_act[1]), 1);
    chk("frz_dx", int'(a_dx), 5);
    chk("frz_pulse", int'(a_p), 0);

    game_state = 2'b00;
    tick();
    chk("rdy_act", int'(a_act), 0);
    chk("rdy_dx", int'(a_dx), 5);
    chk("rdy_x", int'(a_x), int'({12'd640, 12'd640, 12'd640}));
    chk("rdy_c_dx", int'(c_dx), 5);

    game_state = 2'b01;
    @(negedge clk) begin rst = 1'b1; frame_tick = 1'b1; end
    @(negedge clk) begin rst = 1'b0; frame_tick = 1'b0; end
    chk("rstspawn_pulse", int'(a_p), 0);
    chk("rstspawn_act", int'(a_act), 0);
    chk("rstspawn_x0", int'(a_x[11:0]), 640);
    chk("rstspawn_dx", int'(a_dx), 5);
    tick();
    chk("reseed_sel0", int'(a_sel[3:0]), 1);
    chk("reseed_act", int'(a_act), 1);

    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      frame_tick = ($urandom % 3) == 0;
      rst = ($urandom % 400) == 0;
      if (($urandom % 40) == 0) begin
        case ($urandom % 20)
          0:       game_state = 2'b00;
          1, 2:    game_state = 2'b10;
          3:       game_state = 2'b11;
          default: game_state = 2'b01;
        endcase
      end
      if (($urandom % 30) == 0) begin
        int s, w;
        s = $urandom % 3;
        w = $urandom_range(1, 400);
        for (int d = 0; d < 3; d++) wv[d][s] = w;
      end
    end
    @(negedge clk);
    rst = 1'b0;
    frame_tick = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
